// File: rtl/mem_port_arbiter.sv
// Two-master req/gnt arbiter owning all control of a single-port data memory.
// Define ARB_CPU_PRIO_EN for fixed port-0 priority; the default build uses a round-robin tie-break.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, GNT, WAIT, RESP} state_t;

    // MEM_LAT is limited to 1..3, so a 2-bit down-counter suffices
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic              r_last, w_last_nxt;
    logic              r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_mem_we, r_busy;
    logic              w_gnt0_nxt, w_gnt1_nxt, w_rvalid0_nxt, w_rvalid1_nxt, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              w_pick;

`ifdef ARB_CPU_PRIO_EN
    assign w_pick = ~i_req0;
`else
    // On a tie the port that did not win last time goes first
    assign w_pick = (i_req0 & i_req1) ? ~r_last : i_req1;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rvalid0_nxt   = 1'b0;
        w_rvalid1_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        case (r_state)
            IDLE: begin
                if (i_req0 | i_req1) begin
                    w_state_nxt     = GNT;
                    w_last_nxt      = w_pick;
                    w_gnt0_nxt      = ~w_pick;
                    w_gnt1_nxt      = w_pick;
                    w_mem_we_nxt    = w_pick ? i_we1    : i_we0;
                    w_mem_addr_nxt  = w_pick ? i_addr1  : i_addr0;
                    w_mem_wdata_nxt = w_pick ? i_wdata1 : i_wdata0;
                end
            end
            GNT: begin
                if (r_mem_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = LAT_M1;
                end
            end
            WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt   = RESP;
                    w_rdata_nxt   = i_mem_rdata;
                    w_rvalid0_nxt = ~r_last;
                    w_rvalid1_nxt = r_last;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_rvalid0   <= w_rvalid0_nxt;
            r_rvalid1   <= w_rvalid1_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_rdata     = r_rdata;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3), each backed by a behavioural memory,
// checked against a reference memory and the arbitration/latency rules.
module tb_mem_port_arbiter;
    localparam int AW = 10, DW = 32, LAT_A = 1, LAT_B = 3;

    logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    int checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [2][1024];

    always #5 clk = ~clk;

    logic a_req0, a_req1, b_req0, b_req1;
    assign a_req0 = req0 & ~sel;
    assign a_req1 = req1 & ~sel;
    assign b_req0 = req0 & sel;
    assign b_req1 = req1 & sel;

    logic a_g0, a_g1, a_rv0, a_rv1, a_mwe, a_busy;
    logic b_g0, b_g1, b_rv0, b_rv1, b_mwe, b_busy;
    logic [DW-1:0] a_rd, a_mwd, a_mrd, b_rd, b_mwd, b_mrd;
    logic [AW-1:0] a_maddr, b_maddr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req0(a_req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(a_req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt0(a_g0), .o_gnt1(a_g1), .o_rvalid0(a_rv0), .o_rvalid1(a_rv1),
        .o_rdata(a_rd), .o_mem_we(a_mwe), .o_mem_addr(a_maddr), .o_mem_wdata(a_mwd),
        .i_mem_rdata(a_mrd), .o_busy(a_busy));

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req0(b_req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(b_req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt0(b_g0), .o_gnt1(b_g1), .o_rvalid0(b_rv0), .o_rvalid1(b_rv1),
        .o_rdata(b_rd), .o_mem_we(b_mwe), .o_mem_addr(b_maddr), .o_mem_wdata(b_mwd),
        .i_mem_rdata(b_mrd), .o_busy(b_busy));

    // Behavioural memories: write at the clock edge, address held by the arbiter during reads
    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];
    initial begin
        for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        forever begin
            @(posedge clk);
            if (a_mwe) mem_a[a_maddr] = a_mwd;
            if (b_mwe) mem_b[b_maddr] = b_mwd;
        end
    end
    assign a_mrd = mem_a[a_maddr];
    assign b_mrd = mem_b[b_maddr];

    logic o_g0, o_g1, o_rv0, o_rv1;
    logic [DW-1:0] o_rd;
    assign o_g0  = sel ? b_g0  : a_g0;
    assign o_g1  = sel ? b_g1  : a_g1;
    assign o_rv0 = sel ? b_rv0 : a_rv0;
    assign o_rv1 = sel ? b_rv1 : a_rv1;
    assign o_rd  = sel ? b_rd  : a_rd;

    // One access on instance s, port p; reports latencies relative to the sampling edge
    task automatic do_access(input bit s, input bit p, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int glat, output int rlat,
                             output int ngnt, output logic [DW-1:0] rd, output bit bad);
        glat = -1; rlat = -1; ngnt = 0; rd = '0; bad = 1'b0;
        @(posedge clk); #1;
        sel = s;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (p ? o_g1 : o_g0) begin
                ngnt++;
                if (glat < 0) begin glat = k; req0 = 1'b0; req1 = 1'b0; end
            end
            if (p ? (o_g0 || o_rv0) : (o_g1 || o_rv1)) bad = 1'b1;
            if (p ? o_rv1 : o_rv0) begin rlat = k; rd = o_rd; end
            if (w && glat >= 0 && k > glat) break;
            if (!w && rlat >= 0) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        if (w && glat >= 0) ref_mem[s][a] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_g0, a_g1, a_rv0, a_rv1, a_mwe, a_busy} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl_a: got %b want 000000", {a_g0, a_g1, a_rv0, a_rv1, a_mwe, a_busy});
        end
        checks++;
        if (a_maddr !== '0 || a_mwd !== '0 || a_rd !== '0) begin
            errors++; $display("FAIL reset_data_a: addr %h wdata %h rdata %h want 0", a_maddr, a_mwd, a_rd);
        end
        checks++;
        if ({b_g0, b_g1, b_rv0, b_rv1, b_mwe, b_busy, b_maddr, b_mwd, b_rd} !== '0) begin
            errors++; $display("FAIL reset_b: outputs not all zero");
        end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        sel = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_g0, a_g1, a_mwe, a_busy} !== 4'b1011) begin
            errors++; $display("FAIL wr_gnt_cycle: gnt0/gnt1/we/busy got %b want 1011", {a_g0, a_g1, a_mwe, a_busy});
        end
        checks++;
        if (a_maddr !== 10'h005 || a_mwd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bus: addr %h wdata %h want 005 deadbeef", a_maddr, a_mwd);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_g0, a_mwe, a_busy} !== 3'b000) begin
            errors++; $display("FAIL wr_one_cycle: gnt0/we/busy got %b want 000", {a_g0, a_mwe, a_busy});
        end
        ref_mem[0][5] = 32'hDEADBEEF;
    endtask

    task automatic test_read_latency();
        int gl, rl, ng; logic [DW-1:0] rd; bit bad;
        do_access(1'b0, 1'b1, 1'b0, 10'h005, '0, gl, rl, ng, rd, bad);
        checks++;
        if (gl != 1 || rl != 2 + LAT_A || ng != 1) begin
            errors++; $display("FAIL rd_lat1: gnt %0d rvalid %0d ngnt %0d want 1 %0d 1", gl, rl, ng, 2 + LAT_A);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || bad) begin
            errors++; $display("FAIL rd_data1: got %h other-port %0d want deadbeef 0", rd, bad);
        end
        do_access(1'b1, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, gl, rl, ng, rd, bad);
        checks++;
        if (gl != 1 || ng != 1 || bad) begin
            errors++; $display("FAIL wr_lat3: gnt %0d ngnt %0d bad %0d want 1 1 0", gl, ng, bad);
        end
        do_access(1'b1, 1'b1, 1'b0, 10'h005, '0, gl, rl, ng, rd, bad);
        checks++;
        if (gl != 1 || rl != 2 + LAT_B || rd !== 32'hDEADBEEF || bad) begin
            errors++; $display("FAIL rd_lat3: gnt %0d rvalid %0d data %h bad %0d want 1 %0d deadbeef 0",
                               gl, rl, rd, bad, 2 + LAT_B);
        end
    endtask

    task automatic test_round_robin();
        int q_port[$]; int q_cyc[$]; int conc, exp;
        conc = 0;
        do_reset();
        @(posedge clk); #1;
        sel = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h100; wdata0 = 32'hA0A0_0000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'h101; wdata1 = 32'hB1B1_1111;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_g0 && a_g1) conc++;
            if (a_g0 || a_g1) begin q_port.push_back(a_g1 ? 1 : 0); q_cyc.push_back(k); end
            if (q_port.size() == 4) req0 = 1'b0;
            if (q_port.size() == 5) begin req1 = 1'b0; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_mem[0][10'h100] = 32'hA0A0_0000;
        ref_mem[0][10'h101] = 32'hB1B1_1111;
        checks++;
        if (q_port.size() != 5 || conc != 0) begin
            errors++; $display("FAIL rr_count: grants %0d concurrent %0d want 5 0", q_port.size(), conc);
        end else begin
            for (int i = 0; i < 5; i++) begin
`ifdef ARB_CPU_PRIO_EN
                exp = (i < 4) ? 0 : 1;
`else
                exp = (i % 2 == 0) ? 1 : 0;
`endif
                checks++;
                if (q_port[i] != exp) begin
                    errors++; $display("FAIL rr_order[%0d]: got port %0d want %0d", i, q_port[i], exp);
                end
                if (i > 0) begin
                    checks++;
                    if (q_cyc[i] - q_cyc[i-1] != 2) begin
                        errors++; $display("FAIL rr_spacing[%0d]: got %0d want 2", i, q_cyc[i] - q_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int gl, rl, ng, seen; logic [DW-1:0] rd; bit bad;
        seen = 0;
        @(posedge clk); #1;
        sel = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_g0 !== 1'b1) begin errors++; $display("FAIL rst_rd_gnt: got %b want 1", a_g0); end
        req0 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_rd_busy_wait: got %b want 1", a_busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({a_g0, a_g1, a_rv0, a_rv1, a_mwe, a_busy, a_maddr, a_mwd, a_rd} !== '0) begin
            errors++; $display("FAIL rst_rd_outputs: busy %b rv %b%b addr %h rdata %h want all 0",
                               a_busy, a_rv0, a_rv1, a_maddr, a_rd);
        end
        repeat (6) begin @(negedge clk); if (a_rv0 || a_rv1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_rd_no_rvalid: got %0d pulses want 0", seen); end
        do_access(1'b0, 1'b0, 1'b0, 10'h005, '0, gl, rl, ng, rd, bad);
        checks++;
        if (rl != 2 + LAT_A || rd !== ref_mem[0][5]) begin
            errors++; $display("FAIL rst_rd_recover: rvalid %0d data %h want %0d %h", rl, rd, 2 + LAT_A, ref_mem[0][5]);
        end
    endtask

    task automatic test_back_to_back();
        int gl, rl, ng; logic [DW-1:0] rd; bit bad;
        int q_cyc[$]; logic [DW-1:0] q_dat[$];
        for (int i = 1; i <= 3; i++) begin
            do_access(1'b0, 1'b0, 1'b1, AW'(i), DW'(11 * i), gl, rl, ng, rd, bad);
            checks++;
            if (gl != 1) begin errors++; $display("FAIL b2b_wr[%0d]: gnt %0d want 1", i, gl); end
        end
        @(posedge clk); #1;
        sel = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'h001;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_rv0) begin
                q_cyc.push_back(k); q_dat.push_back(a_rd);
                if (q_cyc.size() == 3) begin req0 = 1'b0; break; end
                addr0 = addr0 + 10'd1;
            end
        end
        req0 = 1'b0;
        checks++;
        if (q_cyc.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d rvalids want 3", q_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_dat[i] !== ref_mem[0][i+1]) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, q_dat[i], ref_mem[0][i+1]);
                end
                if (i > 0) begin
                    checks++;
                    if (q_cyc[i] - q_cyc[i-1] != 3 + LAT_A) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, q_cyc[i] - q_cyc[i-1], 3 + LAT_A);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int gl, rl, ng, lat; logic [DW-1:0] rd, exp; bit bad, s, p, w;
        logic [AW-1:0] a; logic [DW-1:0] d;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15)); d = $urandom;
            exp = ref_mem[s][a];
            lat = 2 + (s ? LAT_B : LAT_A);
            do_access(s, p, w, a, d, gl, rl, ng, rd, bad);
            checks++;
            if (gl != 1 || ng != 1 || bad) begin
                errors++; $display("FAIL rnd_gnt[%0d]: lat %0d count %0d other %0d want 1 1 0", i, gl, ng, bad);
            end
            checks++;
            if (!w && (rl != lat || rd !== exp)) begin
                errors++; $display("FAIL rnd_rd[%0d]: lat %0d data %h want %0d %h", i, rl, rd, lat, exp);
            end else if (w && rl != -1) begin
                errors++; $display("FAIL rnd_wr[%0d]: rvalid at %0d want none", i, rl);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin ref_mem[0][i] = '0; ref_mem[1][i] = '0; end
        test_reset();
        test_single_write();
        test_read_latency();
        test_round_robin();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
